// File: rtl/counter_pkg.sv
// Shared types and the next-count rule for the up/down limit counter.
// Counts are carried at a fixed 32-bit width so one function serves any WIDTH.
package counter_pkg;

    typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e;

    typedef enum logic [1:0] {EVT_NONE, EVT_OVF, EVT_UDF} cnt_evt_e;

    localparam int CNT_MAX_W = 32;

    typedef struct packed {
        logic [CNT_MAX_W-1:0] count;
        cnt_evt_e             evt;
    } cnt_result_t;

    function automatic cnt_result_t cnt_next(
        input logic [CNT_MAX_W-1:0] q,
        input logic                 ld,
        input logic                 inc,
        input logic                 dec,
        input logic [CNT_MAX_W-1:0] data_in,
        input logic [CNT_MAX_W-1:0] max_val,
        input cnt_mode_e            mode
    );
        cnt_result_t res;
        res.count = q;
        res.evt   = EVT_NONE;
        if (ld) begin
            res.count = (data_in > max_val) ? max_val : data_in;
        end else if (inc && !dec) begin
            if (q < max_val) begin
                res.count = q + 1'b1;
            end else begin
                res.evt   = EVT_OVF;
                res.count = (mode == CNT_WRAP) ? '0 : max_val;
            end
        end else if (dec && !inc) begin
            if (q != '0) begin
                res.count = q - 1'b1;
            end else begin
                res.evt   = EVT_UDF;
                res.count = (mode == CNT_WRAP) ? max_val : '0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/updown_limit_counter.sv
// Up/down counter with a programmable terminal value, wrap or saturate at the
// limits, a registered terminal-count pulse and sticky overflow/underflow flags.
module updown_limit_counter
    import counter_pkg::*;
#(
    parameter int        WIDTH   = 8,
    parameter longint    MAX_VAL = (64'd1 << WIDTH) - 1,
    parameter cnt_mode_e MODE    = CNT_WRAP,
    parameter longint    RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ld,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             udf
);

    if (WIDTH < 2 || WIDTH > CNT_MAX_W) begin : g_bad_width
        $error("updown_limit_counter: WIDTH must be in 2..32");
    end
    if (MAX_VAL < 0 || MAX_VAL >= (64'd1 << WIDTH)) begin : g_bad_max
        $error("updown_limit_counter: MAX_VAL must fit in WIDTH bits");
    end
    if (RST_VAL < 0 || RST_VAL > MAX_VAL) begin : g_bad_rst
        $error("updown_limit_counter: RST_VAL must not exceed MAX_VAL");
    end

    localparam logic [CNT_MAX_W-1:0] MAX_EXT = MAX_VAL[CNT_MAX_W-1:0];
    localparam logic [WIDTH-1:0]     RST_Q   = RST_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] q_reg, q_next;
    logic             tc_reg, tc_next;
    logic             ovf_reg, ovf_next;
    logic             udf_reg, udf_next;
    cnt_result_t      res;

    always_comb begin
        res      = cnt_next(CNT_MAX_W'(q_reg), ld, inc, dec, CNT_MAX_W'(data_in),
                            MAX_EXT, MODE);
        q_next   = res.count[WIDTH-1:0];
        tc_next  = (res.evt != EVT_NONE);
        // A boundary event in the same cycle as clr_flags leaves the flag set.
        ovf_next = (res.evt == EVT_OVF) || (ovf_reg && !clr_flags);
        udf_next = (res.evt == EVT_UDF) || (udf_reg && !clr_flags);
    end

    if (WIDTH < CNT_MAX_W) begin : g_hi_bits
        logic unused_hi;
        assign unused_hi = ^res.count[CNT_MAX_W-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg   <= RST_Q;
            tc_reg  <= 1'b0;
            ovf_reg <= 1'b0;
            udf_reg <= 1'b0;
        end else begin
            q_reg   <= q_next;
            tc_reg  <= tc_next;
            ovf_reg <= ovf_next;
            udf_reg <= udf_next;
        end
    end

    assign q   = q_reg;
    assign tc  = tc_reg;
    assign ovf = ovf_reg;
    assign udf = udf_reg;

endmodule
